multi_ch_cmd_fsm: RTL
=====================

MULTI_CH_CMD_FSM -- requirements
Module: multi_ch_cmd_fsm

Interface
REQ-001 The block SHALL have parameter NCH, default 4, meaning number of output channels (legal range 2..16).
REQ-002 The block SHALL have parameter HOLD_MIN, default 1, meaning consecutive sampled edges a code must be stable before it is armed (legal range 1..15).
REQ-003 The block SHALL derive CH_W = clog2(NCH) internally; it is not user-settable.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, and all state SHALL change on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port ain, input, CH_W+2 bits: ain[CH_W+1:CH_W] is the opcode and ain[CH_W-1:0] is the channel index.
REQ-007 The block SHALL have port yout, output, NCH bits: registered channel outputs.
REQ-008 The block SHALL have port act, output, 1 bit: high for exactly the one cycle spent in state ACT.
REQ-009 The block SHALL have port err, output, 1 bit: high during an ACT cycle whose channel index is ≥ NCH.
REQ-010 The block SHALL have port glitch, output, 1 bit: a one-cycle pulse when an arming code is abandoned.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in state ARM or state GOT.

Function
REQ-012 Opcodes SHALL be 00 = none (channel bits ignored), 01 = clear, 10 = toggle, 11 = set; a code is the full ain value with a nonzero opcode.
REQ-013 The state machine SHALL be Moore with states IDLE, ARM, GOT, ACT and HOLD, and SHALL latch the code (code_q) and a stability count (cnt) whenever a new nonzero code is sampled.
REQ-014 In IDLE, HOLD or ACT, a sampled nonzero code SHALL go to GOT if HOLD_MIN = 1, else to ARM with cnt = 1; with opcode 00, ACT SHALL go to HOLD and IDLE/HOLD SHALL stay.
REQ-015 In ARM, sampling ain = code_q SHALL increment cnt and go to GOT when the new cnt equals HOLD_MIN; otherwise it SHALL stay in ARM.
REQ-016 In ARM, sampling a different nonzero code SHALL relatch code_q, restart cnt = 1 and stay in ARM, without a glitch pulse.
REQ-017 In ARM, sampling opcode 00 SHALL go to HOLD and pulse glitch for one cycle, leaving yout unchanged.
REQ-018 In GOT, ain = code_q SHALL stay in GOT, and a different nonzero code SHALL be handled exactly as in REQ-014 from IDLE.
REQ-019 In GOT, sampling opcode 00 SHALL go to ACT.
REQ-020 On the edge entering ACT, yout[code_q channel] SHALL be cleared, toggled or set according to the code_q opcode, so the new value is visible during the ACT cycle; all other yout bits SHALL hold.
REQ-021 If the channel index is ≥ NCH, ACT SHALL still occur with act = 1 and err = 1, and yout SHALL be unchanged.
REQ-022 The action latency SHALL be zero edges after the first 00 sample: with HOLD_MIN = 1, a code sampled at edge k followed by 00 at edge k+1 updates yout at edge k+1.
REQ-023 A code replaced by another code without an intervening 00 SHALL never act; only the code that is finally followed by 00 acts.
REQ-024 A repeated identical 00 after ACT SHALL NOT re-act (ACT→HOLD), and HOLD with 00 SHALL be idle indefinitely.

Reset
REQ-025 Reset low SHALL immediately force state IDLE, yout = 0, act = err = glitch = busy = 0, and clear code_q and cnt, independent of clk.
REQ-026 Reset asserted mid-sequence (ARM/GOT) SHALL discard the pending code, so that a 00 sampled after release causes no action.
REQ-027 The first edge after reset release SHALL evaluate ain normally from IDLE.

Structure
REQ-028 Shared package cmd_fsm_pkg SHALL hold the state encoding (3-bit: IDLE, ARM, GOT, ACT, HOLD) and the opcode constants OP_NONE, OP_CLR, OP_TGL and OP_SET.
REQ-029 The stability counter (load-1, increment, compare to HOLD_MIN) SHALL be the one sub-module, cmd_stab_counter; next-state, action and output logic stay in multi_ch_cmd_fsm.

Verification (NCH = 4, ain[3:2] = opcode, ain[1:0] = channel)
REQ-030 The bench SHALL cover set/clear, HOLD_MIN = 1: ain = 1110 for 1 edge then 0000 -> yout = 0100 and act = 1 at that edge; then 0110 then 0000 -> yout = 0000.
REQ-031 The bench SHALL cover toggle and hold: 1000 then 0000 ×3 -> yout[0] flips once and act pulses once.
REQ-032 The bench SHALL cover the glitch case, HOLD_MIN = 3: 1101 for 2 edges then 0000 -> glitch = 1, yout unchanged; 1101 for 3 edges then 0000 -> yout[1] = 1.
REQ-033 The bench SHALL cover out-of-range, NCH = 3: 1111 then 0000 -> act = 1, err = 1, yout unchanged.
REQ-034 The bench SHALL cover replacement: 1101 immediately followed by 1001 then 0000 -> only yout[1] toggles, with no set.
REQ-035 The bench SHALL cover reset mid-operation: 1110 sampled (GOT), reset low for 10 ns, release, 0000 -> yout = 0000, act stays 0.

Source files
------------

// File: rtl/cmd_fsm_pkg.sv
// Shared definitions for the multi-channel command FSM: state encoding,
// opcode constants and the stability counter width.
package cmd_fsm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ARM  = 3'd1,
      ST_GOT  = 3'd2,
      ST_ACT  = 3'd3,
      ST_HOLD = 3'd4
   } state_t;

   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_CLR  = 2'b01;
   localparam logic [1:0] OP_TGL  = 2'b10;
   localparam logic [1:0] OP_SET  = 2'b11;

   // Wide enough for the largest legal HOLD_MIN (15).
   localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/cmd_stab_counter.sv
// Counts consecutive samples of the armed code; hit flags that the next
// matching sample reaches HOLD_MIN.
module cmd_stab_counter
   import cmd_fsm_pkg::*;
#(
   parameter int unsigned HOLD_MIN = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic inc,
   output logic hit
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CNT_W'(1);
      end else if (inc) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign hit = (cnt + CNT_W'(1)) == CNT_W'(HOLD_MIN);

endmodule

// File: rtl/multi_ch_cmd_fsm.sv
// Debounced command decoder: a code held stable for HOLD_MIN samples and then
// released to opcode 00 clears, toggles or sets one channel of yout.
module multi_ch_cmd_fsm
   import cmd_fsm_pkg::*;
#(
   parameter  int unsigned NCH      = 4,
   parameter  int unsigned HOLD_MIN = 1,
   localparam int unsigned CH_W     = $clog2(NCH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [CH_W+1:0] ain,
   output logic [NCH-1:0]  yout,
   output logic            act,
   output logic            err,
   output logic            glitch,
   output logic            busy
);

   state_t          state, state_nxt, first_st;
   logic [CH_W+1:0] code_q;
   logic [1:0]      op_in, op_q;
   logic [CH_W-1:0] ch_q;
   logic [NCH-1:0]  ch_mask, yout_nxt;
   logic            ch_oor;
   logic            cnt_load, cnt_inc, cnt_hit;

   assign op_in    = ain[CH_W+1:CH_W];
   assign op_q     = code_q[CH_W+1:CH_W];
   assign ch_q     = code_q[CH_W-1:0];
   assign first_st = (HOLD_MIN == 1) ? ST_GOT : ST_ARM;
   assign ch_oor   = 32'(ch_q) >= NCH;
   // An out-of-range index shifts the bit out entirely, so yout holds.
   assign ch_mask  = {{(NCH-1){1'b0}}, 1'b1} << ch_q;

   cmd_stab_counter #(.HOLD_MIN(HOLD_MIN)) u_stab (
      .clk   (clk),
      .reset (reset),
      .load  (cnt_load),
      .inc   (cnt_inc),
      .hit   (cnt_hit)
   );

   always_comb begin
      state_nxt = state;
      cnt_load  = 1'b0;
      cnt_inc   = 1'b0;
      unique case (state)
         ST_IDLE, ST_HOLD, ST_ACT: begin
            if (op_in != OP_NONE) begin
               state_nxt = first_st;
               cnt_load  = 1'b1;
            end else if (state == ST_ACT) begin
               state_nxt = ST_HOLD;
            end
         end
         ST_ARM: begin
            if (op_in == OP_NONE) begin
               state_nxt = ST_HOLD;
            end else if (ain == code_q) begin
               cnt_inc = 1'b1;
               if (cnt_hit) state_nxt = ST_GOT;
            end else begin
               cnt_load = 1'b1;
            end
         end
         ST_GOT: begin
            if (op_in == OP_NONE) begin
               state_nxt = ST_ACT;
            end else if (ain != code_q) begin
               state_nxt = first_st;
               cnt_load  = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      yout_nxt = yout;
      unique case (op_q)
         OP_CLR:  yout_nxt = yout & ~ch_mask;
         OP_TGL:  yout_nxt = yout ^ ch_mask;
         OP_SET:  yout_nxt = yout | ch_mask;
         default: yout_nxt = yout;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ST_IDLE;
         code_q <= '0;
         yout   <= '0;
         act    <= 1'b0;
         err    <= 1'b0;
         glitch <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_nxt;
         if (cnt_load) code_q <= ain;
         act    <= (state_nxt == ST_ACT);
         err    <= (state_nxt == ST_ACT) && ch_oor;
         glitch <= (state == ST_ARM) && (state_nxt == ST_HOLD);
         busy   <= (state_nxt == ST_ARM) || (state_nxt == ST_GOT);
         if (state == ST_GOT && state_nxt == ST_ACT) yout <= yout_nxt;
      end
   end

endmodule
